// File: rtl/pc_sel_ctrl.sv
// ============================================================================
// pc_sel_ctrl : fetch PC-source select with EPC/cause/pending state and a
//               saturating exception counter. Optional macro PCSEL_VECTORED_EN
//               selects vectored handler entry.  Revision: 1.0
// ============================================================================
`default_nettype none

module pc_sel_ctrl #(
  parameter logic [31:0] HANDLER_BASE = 32'h0000_0100
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_pc,
  input  logic        i_branch,
  input  logic [3:0]  i_exc_req,
  input  logic        i_eret,
  output logic [1:0]  o_pcsrc,
  output logic [31:0] o_epc,
  output logic [31:0] o_handler_addr,
  output logic [1:0]  o_cause,
  output logic [3:0]  o_pending,
  output logic        o_in_handler,
  output logic        o_flush,
  output logic [7:0]  o_exc_count
);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    HANDLER = 1'b1
  } state_t;

  localparam logic [1:0] SRC_SEQ = 2'b00;
  localparam logic [1:0] SRC_EXE = 2'b01;
  localparam logic [1:0] SRC_EPC = 2'b10;
  localparam logic [1:0] SRC_HDL = 2'b11;

  state_t      state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic [1:0]  cause_q, cause_d;
  logic [3:0]  pending_q, pending_d;
  logic [7:0]  count_q, count_d;
  logic [1:0]  pcsrc_d;
  logic [3:0]  pend_all;
  logic        take_exc;

  // Lowest set bit index has the highest priority.
  function automatic logic [1:0] prio_idx(input logic [3:0] req);
    logic [1:0] idx;
    idx = 2'd0;
    if (req[3]) idx = 2'd3;
    if (req[2]) idx = 2'd2;
    if (req[1]) idx = 2'd1;
    if (req[0]) idx = 2'd0;
    return idx;
  endfunction

  always_comb begin
    state_d   = state_q;
    epc_d     = epc_q;
    cause_d   = cause_q;
    pending_d = pending_q;
    pcsrc_d   = SRC_SEQ;
    take_exc  = 1'b0;
    pend_all  = pending_q | i_exc_req;

    unique case (state_q)
      RUN: begin
        if (|i_exc_req) begin
          pcsrc_d  = SRC_HDL;
          epc_d    = i_pc;
          cause_d  = prio_idx(i_exc_req);
          state_d  = HANDLER;
          take_exc = 1'b1;
        end else if (i_branch) begin
          pcsrc_d = SRC_EXE;
        end
      end
      HANDLER: begin
        // New requests join pending before the eret chain decision.
        pending_d = pend_all;
        if (i_eret) begin
          if (pend_all == 4'b0000) begin
            pcsrc_d = SRC_EPC;
            state_d = RUN;
          end else begin
            pcsrc_d   = SRC_HDL;
            cause_d   = prio_idx(pend_all);
            pending_d = pend_all & ~(4'b0001 << prio_idx(pend_all));
            take_exc  = 1'b1;
          end
        end else if (i_branch) begin
          pcsrc_d = SRC_EXE;
        end
      end
      default: state_d = RUN;
    endcase

    count_d = (take_exc && count_q != 8'hFF) ? count_q + 8'd1 : count_q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= RUN;
      epc_q     <= 32'd0;
      cause_q   <= 2'd0;
      pending_q <= 4'd0;
      count_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      epc_q     <= epc_d;
      cause_q   <= cause_d;
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  assign o_pcsrc      = i_rst_n ? pcsrc_d : SRC_SEQ;
  assign o_flush      = (o_pcsrc != SRC_SEQ);
  assign o_epc        = epc_q;
  assign o_cause      = cause_q;
  assign o_pending    = pending_q;
  assign o_in_handler = (state_q == HANDLER);
  assign o_exc_count  = count_q;

`ifdef PCSEL_VECTORED_EN
  // Offset follows the cause being entered, so it is valid in the entry cycle.
  assign o_handler_addr = HANDLER_BASE + {26'd0, cause_d, 4'd0};
`else
  assign o_handler_addr = HANDLER_BASE;
`endif

endmodule

`default_nettype wire
